// File: rtl/row_hamming_enc_tx.sv
// row_hamming_enc_tx
//   Buffers 8-bit binary row addresses in a small FIFO, Gray-codes and
//   Hamming-encodes each into a 12-bit row code, and drives it onto the row
//   bus with a 4-phase valid/ack handshake. Supports one-shot single-bit
//   error injection, ack-timeout recovery and status counters.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   row_in, row_we      row address and write strobe (ignored when full)
//   row_full            FIFO holds FIFO_DEPTH entries
//   inj_en, inj_bit     arm injection of bit inj_bit into the next code
//   code_out, code_valid, code_ack   row-bus 4-phase handshake
//   busy                FSM active or FIFO not empty
//   sent_cnt            acknowledged codes (wraps)
//   timeout_cnt         abandoned codes (saturates)
//   drop_cnt            refused writes (saturates)
module row_hamming_enc_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  row_in,
  input  logic        row_we,
  output logic        row_full,
  input  logic        inj_en,
  input  logic [3:0]  inj_bit,
  output logic [11:0] code_out,
  output logic        code_valid,
  input  logic        code_ack,
  output logic        busy,
  output logic [15:0] sent_cnt,
  output logic [7:0]  timeout_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRIVE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [11:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          inj_armed_q, inj_armed_d;
  logic [3:0]    inj_idx_q, inj_idx_d;
  logic [15:0]   sent_q, sent_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop, full;
  logic [11:0]   enc;

  function automatic logic [11:0] encode(input logic [7:0] b);
    logic [7:0]  g;
    logic [11:0] c;
    g     = b ^ (b >> 1);
    c     = '0;
    c[2]  = g[0];
    c[4]  = g[1];
    c[5]  = g[2];
    c[11] = g[3];
    c[8]  = g[4];
    c[9]  = g[5];
    c[10] = g[6];
    c[6]  = g[7];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  assign full = (count_q == CW'(FIFO_DEPTH));
  // A full FIFO refuses the write even if the FSM pops in the same cycle.
  assign push = row_we && !full;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    valid_d     = valid_q;
    tmo_d       = tmo_q;
    inj_armed_d = inj_armed_q;
    inj_idx_d   = inj_idx_q;
    sent_d      = sent_q;
    tcnt_d      = tcnt_q;
    drop_d      = drop_q;
    pop         = 1'b0;
    enc         = encode(mem_q[rd_ptr_q]);
    if (inj_armed_q && (inj_idx_q < 4'd12)) begin
      enc = enc ^ (12'd1 << inj_idx_q);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          code_d      = enc;
          valid_d     = 1'b1;
          tmo_d       = '0;
          inj_armed_d = 1'b0;
          state_d     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (code_ack) begin
          valid_d = 1'b0;
          sent_d  = sent_q + 16'd1;
          state_d = S_RELEASE;
        end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
          valid_d = 1'b0;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = S_RELEASE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (!code_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pulse on the load cycle arms for the following load, not this one.
    if (inj_en) begin
      inj_armed_d = 1'b1;
      inj_idx_d   = inj_bit;
    end

    if (row_we && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= row_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      code_q      <= '0;
      valid_q     <= 1'b0;
      tmo_q       <= '0;
      inj_armed_q <= 1'b0;
      inj_idx_q   <= '0;
      sent_q      <= '0;
      tcnt_q      <= '0;
      drop_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      inj_armed_q <= inj_armed_d;
      inj_idx_q   <= inj_idx_d;
      sent_q      <= sent_d;
      tcnt_q      <= tcnt_d;
      drop_q      <= drop_d;
    end
  end

  assign row_full    = full;
  assign code_out    = code_q;
  assign code_valid  = valid_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign sent_cnt    = sent_q;
  assign timeout_cnt = tcnt_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_row_hamming_enc_tx.sv
module tb_row_hamming_enc_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  row_in = '0;
  logic        row_we = 1'b0;
  logic        row_full;
  logic        inj_en = 1'b0;
  logic [3:0]  inj_bit = '0;
  logic [11:0] code_out;
  logic        code_valid;
  logic        code_ack = 1'b0;
  logic        busy;
  logic [15:0] sent_cnt;
  logic [7:0]  timeout_cnt;
  logic [7:0]  drop_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  row_hamming_enc_tx #(
    .FIFO_DEPTH (4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .row_we     (row_we),
    .row_full   (row_full),
    .inj_en     (inj_en),
    .inj_bit    (inj_bit),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ack   (code_ack),
    .busy       (busy),
    .sent_cnt   (sent_cnt),
    .timeout_cnt(timeout_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [7:0] r);
    row_in = r;
    row_we = 1'b1;
    step();
    row_we = 1'b0;
  endtask

  // Single transfer into an idle DUT with an immediate consumer.
  task automatic xfer(input string tag, input logic [7:0] r, input logic [11:0] exp);
    write_row(r);
    step();
    check({tag, "_valid"}, 32'(code_valid), 32'd1);
    check({tag, "_code"}, 32'(code_out), 32'(exp));
    code_ack = 1'b1;
    step();
    check({tag, "_drop"}, 32'(code_valid), 32'd0);
    code_ack = 1'b0;
    step();
  endtask

  initial begin
    int unsigned hi;

    step();
    step();
    check("rst_code", 32'(code_out), 32'h0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_full", 32'(row_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", 32'(sent_cnt), 32'd0);
    check("rst_tmo", 32'(timeout_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Encoding
    xfer("enc00", 8'h00, 12'h000);
    xfer("enc01", 8'h01, 12'h007);
    xfer("encff", 8'hFF, 12'h04B);
    xfer("enc80", 8'h80, 12'h4C8);
    check("enc_sent", 32'(sent_cnt), 32'd4);

    // Injection: one-shot, out-of-range index, overwrite
    inj_en = 1'b1; inj_bit = 4'd5; step(); inj_en = 1'b0;
    xfer("inj5", 8'h01, 12'h027);
    xfer("inj_clr", 8'h01, 12'h007);
    inj_en = 1'b1; inj_bit = 4'd13; step(); inj_en = 1'b0;
    xfer("inj13", 8'h01, 12'h007);
    xfer("inj13_after", 8'hFF, 12'h04B);
    inj_en = 1'b1; inj_bit = 4'd0; step();
    inj_bit = 4'd11; step(); inj_en = 1'b0;
    xfer("inj_ovr", 8'h00, 12'h800);
    check("inj_sent", 32'(sent_cnt), 32'd9);

    // Handshake timing: ack rises 3 cycles after valid, falls 2 later
    row_in = 8'h02; row_we = 1'b1; step();
    row_in = 8'h03; step();                     // edge V: 0x02 loaded
    row_we = 1'b0;
    check("hs_valid", 32'(code_valid), 32'd1);
    check("hs_code", 32'(code_out), 32'h01E);
    step(); step(); step();                     // after V+3
    check("hs_hold", 32'(code_valid), 32'd1);
    code_ack = 1'b1;
    step();                                     // V+4
    check("hs_drop", 32'(code_valid), 32'd0);
    step();                                     // V+5
    code_ack = 1'b0;
    step();                                     // V+6: back in IDLE
    check("hs_gap", 32'(code_valid), 32'd0);
    step();                                     // V+7
    check("hs_next_valid", 32'(code_valid), 32'd1);
    check("hs_next_code", 32'(code_out), 32'h019);
    code_ack = 1'b1; step(); code_ack = 1'b0; step();
    check("hs_sent", 32'(sent_cnt), 32'd11);
    check("hs_idle", 32'(busy), 32'd0);

    // Full FIFO with ack held low
    for (int i = 0; i < 6; i++) begin
      row_in = 8'(8'h10 + i);
      row_we = 1'b1;
      step();
    end
    row_we = 1'b0;
    check("full_flag", 32'(row_full), 32'd1);
    check("full_drop", 32'(drop_cnt), 32'd1);
    check("full_code", 32'(code_out), 32'h909);
    check("full_busy", 32'(busy), 32'd1);
    step(); step(); step();
    check("full_pre_tmo", 32'(code_valid), 32'd1);
    step();
    check("full_tmo_drop", 32'(code_valid), 32'd0);
    check("full_tmo_cnt", 32'(timeout_cnt), 32'd1);
    step(); step();
    check("full_next_code", 32'(code_out), 32'h90E);
    check("full_next_valid", 32'(code_valid), 32'd1);
    check("full_after_pop", 32'(row_full), 32'd0);

    // Reset mid-DRIVE with 3 entries queued
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_valid", 32'(code_valid), 32'd0);
    check("mrst_full", 32'(row_full), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_cnts", {8'd0, sent_cnt, timeout_cnt ^ drop_cnt}, 32'd0);
    check("mrst_tmo", 32'(timeout_cnt), 32'd0);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (code_valid) hi++;
    end
    check("mrst_quiet", hi, 32'd0);

    // Timeout: valid high for exactly ACK_TIMEOUT cycles
    write_row(8'h10);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (code_valid) hi++;
    end
    check("tmo_len", hi, 32'd8);
    check("tmo_cnt", 32'(timeout_cnt), 32'd1);
    check("tmo_sent", 32'(sent_cnt), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
